display_scanner: RTL and testbench



---
 rtl/display_scanner.sv | 155 +++++++++++++++
 tb/tb_display_scanner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// Display-slot scanner: sweeps slot indices, captures each valid slot and streams it as "NAME=HHHHHHHH\r\n".
// Optional DISPLAY_SCANNER_AUTO_EN makes sweeps repeat continuously after the first start.
module display_scanner #(
    parameter logic [5:0] FIRST_INDEX  = 6'd1,
    parameter logic [5:0] LAST_INDEX   = 6'd32,
    parameter int         RESP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [5:0]  display_number,
    input  logic        display_valid,
    input  logic [39:0] display_name,
    input  logic [31:0] display_value,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready
);

    typedef enum logic [2:0] {IDLE, REQ, CAPT, EMIT, NEXT, FIN} state_t;

    state_t      state_reg;
    logic [5:0]  idx_reg;
    logic [2:0]  wait_reg;
    logic [3:0]  ptr_reg;
    logic [39:0] name_reg;
    logic [31:0] value_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [5:0]  number_reg;
    logic        char_valid_reg;
    logic [7:0]  char_data_reg;
    logic [7:0]  line_char [16];

    // Byte p of a formatted line; used directly on the provider bus for byte 0.
    function automatic logic [7:0] char_at(input int p, input logic [39:0] nm, input logic [31:0] v);
        logic [7:0] c;
        logic [3:0] nib;
        c   = 8'h00;
        nib = 4'h0;
        if (p < 5) begin
            c = nm[8*(4-p) +: 8];
            if (c == 8'h00) c = 8'h20;
        end else if (p == 5) begin
            c = 8'h3D;
        end else if (p < 14) begin
            nib = v[4*(13-p) +: 4];
            c   = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end else if (p == 14) begin
            c = 8'h0D;
        end else begin
            c = 8'h0A;
        end
        return c;
    endfunction

    for (genvar gi = 0; gi < 16; gi++) begin : g_line
        assign line_char[gi] = char_at(gi, name_reg, value_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            idx_reg        <= 6'd0;
            wait_reg       <= 3'd0;
            ptr_reg        <= 4'd0;
            name_reg       <= 40'h0;
            value_reg      <= 32'h0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            number_reg     <= 6'd0;
            char_valid_reg <= 1'b0;
            char_data_reg  <= 8'h00;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        idx_reg    <= FIRST_INDEX;
                        number_reg <= FIRST_INDEX;
                        wait_reg   <= 3'd0;
                        busy_reg   <= 1'b1;
                        state_reg  <= REQ;
                    end
                end
                REQ: begin
                    if (wait_reg == 3'(RESP_LATENCY - 1)) begin
                        state_reg <= CAPT;
                    end else begin
                        wait_reg <= wait_reg + 3'd1;
                    end
                end
                CAPT: begin
                    name_reg  <= display_name;
                    value_reg <= display_value;
                    if (display_valid) begin
                        ptr_reg        <= 4'd0;
                        char_valid_reg <= 1'b1;
                        char_data_reg  <= char_at(0, display_name, display_value);
                        state_reg      <= EMIT;
                    end else begin
                        state_reg <= NEXT;
                    end
                end
                EMIT: begin
                    if (char_ready) begin
                        if (ptr_reg == 4'd15) begin
                            char_valid_reg <= 1'b0;
                            char_data_reg  <= 8'h00;
                            state_reg      <= NEXT;
                        end else begin
                            ptr_reg       <= ptr_reg + 4'd1;
                            char_data_reg <= line_char[4'(ptr_reg + 4'd1)];
                        end
                    end
                end
                NEXT: begin
                    // Compare before incrementing so LAST_INDEX = 63 never wraps to 0.
                    if (idx_reg == LAST_INDEX) begin
                        done_reg   <= 1'b1;
                        busy_reg   <= 1'b0;
                        number_reg <= 6'd0;
                        state_reg  <= FIN;
                    end else begin
                        idx_reg    <= idx_reg + 6'd1;
                        number_reg <= idx_reg + 6'd1;
                        wait_reg   <= 3'd0;
                        state_reg  <= REQ;
                    end
                end
                FIN: begin
`ifdef DISPLAY_SCANNER_AUTO_EN
                    idx_reg    <= FIRST_INDEX;
                    number_reg <= FIRST_INDEX;
                    wait_reg   <= 3'd0;
                    busy_reg   <= 1'b1;
                    state_reg  <= REQ;
`else
                    state_reg <= IDLE;
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign display_number = number_reg;
    assign char_valid     = char_valid_reg;
    assign char_data      = char_data_reg;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: two instances (slots 1..4 and the single slot 63),
// each fed by a registered 1-cycle provider model.
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rdy = 1'b1;
    logic        bp = 1'b0;
    logic        nullm = 1'b0;
    logic        start [2];
    logic        busy [2];
    logic        done [2];
    logic [5:0]  dn [2];
    logic        pv [2];
    logic [39:0] pn [2];
    logic [31:0] pval [2];
    logic        cv [2];
    logic [7:0]  cd [2];

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt [2];
    int          xfer [2];
    logic        stall [2];
    logic [7:0]  stall_data [2];

    localparam string BASIC = "SRC_1=12345678\r\nSRC_2=0000ABCD\r\nRESUL=FFFFFFFF\r\n";

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        display_scanner #(
            .FIRST_INDEX (gi == 0 ? 6'd1 : 6'd63),
            .LAST_INDEX  (gi == 0 ? 6'd4 : 6'd63),
            .RESP_LATENCY(1)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .start         (start[gi]),
            .busy          (busy[gi]),
            .done          (done[gi]),
            .display_number(dn[gi]),
            .display_valid (pv[gi]),
            .display_name  (pn[gi]),
            .display_value (pval[gi]),
            .char_valid    (cv[gi]),
            .char_data     (cd[gi]),
            .char_ready    (rdy)
        );
    end

    function automatic logic [72:0] prov(input int k, input logic [5:0] n, input logic nm);
        logic [72:0] r;
        r = {1'b0, 40'h5858585858, 32'hDEADBEEF};
        if (k == 0) begin
            if (n == 6'd1) r = nm ? {1'b1, 16'h4142, 24'h0, 32'h0} : {1'b1, 40'h5352435F31, 32'h12345678};
            else if (n == 6'd2) r = {1'b1, 40'h5352435F32, 32'h0000ABCD};
            else if (n == 6'd4) r = {1'b1, 40'h524553554C, 32'hFFFFFFFF};
        end else if (n == 6'd63) begin
            r = {1'b1, 40'h4544474536, 32'h0000003F};
        end
        return r;
    endfunction

    // Registered provider: response follows display_number by one edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            {pv[k], pn[k], pval[k]} <= prov(k, dn[k], nullm);
        end
    end

    // Backpressure driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_byte(input int k, input logic [7:0] d);
        logic [7:0] e;
        n_cmp++;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            n_bad++;
            $display("FAIL byte%0d: got unexpected byte %h, required no byte", k, d);
        end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            if (d !== e) begin
                n_bad++;
                $display("FAIL byte%0d: got %h, required %h", k, d, e);
            end else begin
                $display("dut%0d byte %h ok", k, d);
            end
        end
    endtask

    // Monitor: bytes whose handshake completes on the next edge, hold rule, done/busy.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                stall[k] = 1'b0;
            end else begin
                if (stall[k]) begin
                    n_cmp++;
                    if (!(cv[k] === 1'b1 && cd[k] === stall_data[k])) begin
                        n_bad++;
                        $display("FAIL hold%0d: got valid=%b data=%h, required valid=1 data=%h",
                                 k, cv[k], cd[k], stall_data[k]);
                    end
                end
                if (cv[k] && rdy) begin
                    xfer[k]++;
                    check_byte(k, cd[k]);
                end
                if (done[k]) begin
                    done_cnt[k]++;
                    chk("busy_at_done", 64'(busy[k]), 64'd0);
                    $display("dut%0d done pulse %0d", k, done_cnt[k]);
                end
                stall[k]      = cv[k] && !rdy;
                stall_data[k] = cd[k];
            end
        end
    end

    task automatic push_str(input int k, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (k == 0) q0.push_back(s[i]);
            else q1.push_back(s[i]);
        end
    endtask

    task automatic pulse_start(input int k);
        @(posedge clk);
        #1 start[k] = 1'b1;
        @(posedge clk);
        #1 start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int base;
        base = done_cnt[k];
        for (int c = 0; c < budget && done_cnt[k] == base; c++) @(posedge clk);
        if (done_cnt[k] == base) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic sweep0(input string s, input int budget);
        push_str(0, s);
        pulse_start(0);
        @(negedge clk);
        chk("busy_after_start", 64'(busy[0]), 64'd1);
        wait_done(0, budget);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_after_done", 64'(busy[0]), 64'd0);
        chk("q0_drained", 64'(q0.size()), 64'd0);
    endtask

    initial begin
        int base;
        start[0] = 1'b0;
        start[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            done_cnt[k] = 0;
            xfer[k]     = 0;
            stall[k]    = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", 64'(busy[k]), 64'd0);
            chk("rst_done", 64'(done[k]), 64'd0);
            chk("rst_number", 64'(dn[k]), 64'd0);
            chk("rst_valid", 64'(cv[k]), 64'd0);
            chk("rst_data", 64'(cd[k]), 64'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

`ifdef DISPLAY_SCANNER_AUTO_EN
        push_str(0, BASIC);
        push_str(0, BASIC);
        push_str(0, BASIC);
        pulse_start(0);
        for (int s = 0; s < 3; s++) wait_done(0, 400);
        chk("auto_q0_drained", 64'(q0.size()), 64'd0);
        chk("auto_done_count", 64'(done_cnt[0]), 64'd3);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("auto_rst_valid", 64'(cv[0]), 64'd0);
        chk("auto_rst_busy", 64'(busy[0]), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
`else
        // Basic sweep, then the same stream under random backpressure.
        sweep0(BASIC, 400);
        bp = 1'b1;
        sweep0(BASIC, 1500);
        bp = 1'b0;

        // Null-padded name on slot 1.
        nullm = 1'b1;
        sweep0("AB   =00000000\r\nSRC_2=0000ABCD\r\nRESUL=FFFFFFFF\r\n", 400);
        nullm = 1'b0;

        // Second start mid-sweep is ignored.
        base = done_cnt[0];
        push_str(0, BASIC);
        pulse_start(0);
        repeat (20) @(posedge clk);
        pulse_start(0);
        wait_done(0, 400);
        repeat (150) @(posedge clk);
        chk("single_done", 64'(done_cnt[0]), 64'(base + 1));
        chk("q0_after_restart", 64'(q0.size()), 64'd0);

        // Reset right after the 7th byte transfers.
        base = xfer[0];
        push_str(0, BASIC);
        pulse_start(0);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (xfer[0] == base + 7) break;
        end
        chk("seven_bytes", 64'(xfer[0]), 64'(base + 7));
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_valid", 64'(cv[0]), 64'd0);
        chk("abort_number", 64'(dn[0]), 64'd0);
        q0.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        sweep0(BASIC, 400);

        // Single-slot sweep at index 63.
        push_str(1, "EDGE6=0000003F\r\n");
        pulse_start(1);
        wait_done(1, 300);
        repeat (40) @(posedge clk);
        chk("edge_done_count", 64'(done_cnt[1]), 64'd1);
        chk("edge_q1_drained", 64'(q1.size()), 64'd0);
        chk("edge_number_idle", 64'(dn[1]), 64'd0);
`endif
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
